// File: rtl/core_writeback_arbiter.sv
// rtl/core_writeback_arbiter.sv - five-unit result buffer and dual write-port scheduler
//
// Purpose: buffers one result per execution unit (0=alu_a, 1=alu_b, 2=branch,
// 3=ldst, 4=mul) and retires up to two per cycle onto register-file write ports
// A and B. Grants rotate from rr_ptr. Writes to the same register keep arrival order.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   src_valid/src_rd/src_value per-unit result offer (rd 4b, value 32b per unit)
//   src_stall, wb_stall_branch per-unit back-pressure (branch copy separately)
//   wr_a_*, wr_b_*             write ports, combinational from buffer state
//   pending_mask               one-hot OR of rd over all occupied buffers
//   perf_stall_cycles          saturating stall-cycle counter
//
// Optional: define WB_PERF_EN to build the counter; otherwise it is tied to 0.
module core_writeback_arbiter #(
  parameter int RR_INIT = 0,
  parameter int PERF_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        src_valid,
  input  logic [19:0]       src_rd,
  input  logic [159:0]      src_value,
  output logic [4:0]        src_stall,
  output logic              wb_stall_branch,
  output logic              wr_a_en,
  output logic [3:0]        wr_a_rd,
  output logic [31:0]       wr_a_value,
  output logic              wr_b_en,
  output logic [3:0]        wr_b_rd,
  output logic [31:0]       wr_b_value,
  output logic [15:0]       pending_mask,
  output logic [PERF_W-1:0] perf_stall_cycles
);
  localparam int N = 5;

  logic [N-1:0] occ;
  logic [3:0]   rd_q  [N];
  logic [31:0]  val_q [N];
  logic [N-1:0] older [N];       // older[i][j]: entry i arrived before entry j
  logic [2:0]   rr_ptr;

  logic [N-1:0] elig;
  logic [N-1:0] gnt;
  logic [N-1:0] cap;
  logic         found_a;
  logic         found_b;
  logic [2:0]   idx_a;
  logic [2:0]   idx_b;
  logic [2:0]   scan_idx;
  logic [3:0]   scan_sum;
  logic [2:0]   last_idx;
  logic [2:0]   rr_next;
  logic [N-1:0] older_next [N];

  // An entry may retire only when no older occupied entry targets the same rd.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      elig[i] = occ[i];
      for (int j = 0; j < N; j++) begin
        if (occ[j] && older[j][i] && (rd_q[j] == rd_q[i])) elig[i] = 1'b0;
      end
    end
  end

  // Rotating scan from rr_ptr: first eligible hit goes to port A, second to B.
  always_comb begin
    found_a  = 1'b0;
    found_b  = 1'b0;
    idx_a    = 3'd0;
    idx_b    = 3'd0;
    scan_sum = 4'd0;
    scan_idx = 3'd0;
    for (int k = 0; k < N; k++) begin
      scan_sum = 4'(rr_ptr) + 4'(k);
      scan_idx = (scan_sum >= 4'd5) ? 3'(scan_sum - 4'd5) : 3'(scan_sum);
      if (elig[scan_idx]) begin
        if (!found_a) begin
          found_a = 1'b1;
          idx_a   = scan_idx;
        end else if (!found_b) begin
          found_b = 1'b1;
          idx_b   = scan_idx;
        end
      end
    end
    gnt = '0;
    if (found_a) gnt[idx_a] = 1'b1;
    if (found_b) gnt[idx_b] = 1'b1;
  end

  assign last_idx = found_b ? idx_b : idx_a;
  assign rr_next  = (last_idx == 3'd4) ? 3'd0 : last_idx + 3'd1;

  // No write may leave the block in a cycle where rst is asserted.
  assign wr_a_en    = found_a & ~rst;
  assign wr_a_rd    = rd_q[idx_a];
  assign wr_a_value = val_q[idx_a];
  assign wr_b_en    = found_b & ~rst;
  assign wr_b_rd    = rd_q[idx_b];
  assign wr_b_value = val_q[idx_b];

  // src_stall also marks entries that survive this edge; cap may refill a
  // buffer that is being granted in the same cycle.
  assign src_stall       = occ & ~gnt;
  assign wb_stall_branch = src_stall[2];
  assign cap             = src_valid & ~src_stall;

  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < N; i++) begin
      if (occ[i]) pending_mask[rd_q[i]] = 1'b1;
    end
  end

  // Age matrix update. A new entry is younger than every survivor, and among
  // same-cycle arrivals the lower unit index is older. Cleared entries lose
  // their row and column.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      older_next[i] = '0;
      for (int j = 0; j < N; j++) begin
        if (i == j) begin
          older_next[i][j] = 1'b0;
        end else if (cap[j]) begin
          older_next[i][j] = src_stall[i] | (cap[i] && (i < j));
        end else if (cap[i]) begin
          older_next[i][j] = 1'b0;
        end else if (gnt[i] || gnt[j]) begin
          older_next[i][j] = 1'b0;
        end else begin
          older_next[i][j] = older[i][j];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ    <= '0;
      rr_ptr <= 3'(RR_INIT);
      for (int i = 0; i < N; i++) older[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        older[i] <= older_next[i];
        if (cap[i]) begin
          occ[i]   <= 1'b1;
          rd_q[i]  <= src_rd[4*i +: 4];
          val_q[i] <= src_value[32*i +: 32];
        end else if (gnt[i]) begin
          occ[i] <= 1'b0;
        end
      end
      if (found_a) rr_ptr <= rr_next;
    end
  end

`ifdef WB_PERF_EN
  logic [PERF_W-1:0] perf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_q <= '0;
    end else if (|src_stall && !(&perf_q)) begin
      perf_q <= perf_q + PERF_W'(1);
    end
  end

  assign perf_stall_cycles = perf_q;
`else
  assign perf_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_core_writeback_arbiter.sv
// tb/tb_core_writeback_arbiter.sv - self-checking bench for core_writeback_arbiter
module tb_core_writeback_arbiter;
  localparam int PW       = 4;
  localparam int PERF_MAX = 15;
`ifdef WB_PERF_EN
  localparam bit PERF_ON = 1'b1;
`else
  localparam bit PERF_ON = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic [4:0]    src_valid;
  logic [19:0]   src_rd;
  logic [159:0]  src_value;
  logic [4:0]    src_stall;
  logic          wb_stall_branch;
  logic          wr_a_en;
  logic [3:0]    wr_a_rd;
  logic [31:0]   wr_a_value;
  logic          wr_b_en;
  logic [3:0]    wr_b_rd;
  logic [31:0]   wr_b_value;
  logic [15:0]   pending_mask;
  logic [PW-1:0] perf_stall_cycles;

  int checks   = 0;
  int failures = 0;

  core_writeback_arbiter #(.RR_INIT(0), .PERF_W(PW)) dut (
    .clk              (clk),
    .rst              (rst),
    .src_valid        (src_valid),
    .src_rd           (src_rd),
    .src_value        (src_value),
    .src_stall        (src_stall),
    .wb_stall_branch  (wb_stall_branch),
    .wr_a_en          (wr_a_en),
    .wr_a_rd          (wr_a_rd),
    .wr_a_value       (wr_a_value),
    .wr_b_en          (wr_b_en),
    .wr_b_rd          (wr_b_rd),
    .wr_b_value       (wr_b_value),
    .pending_mask     (pending_mask),
    .perf_stall_cycles(perf_stall_cycles)
  );

  always #5 clk = ~clk;

  // Reference model: each buffer carries an arrival sequence number.
  bit          m_occ [5];
  logic [3:0]  m_rd  [5];
  logic [31:0] m_val [5];
  int unsigned m_seq [5];
  int unsigned seq_ctr;
  int          m_rr;
  int          m_perf;
  int          e_a;
  int          e_b;
  logic [4:0]  e_stall;
  logic [15:0] e_mask;

  task automatic model_reset();
    for (int i = 0; i < 5; i++) begin
      m_occ[i] = 0;
      m_rd[i]  = '0;
      m_val[i] = '0;
      m_seq[i] = 0;
    end
    seq_ctr = 0;
    m_rr    = 0;
    m_perf  = 0;
  endtask

  task automatic model_eval();
    e_a = -1;
    e_b = -1;
    e_stall = '0;
    e_mask  = '0;
    for (int k = 0; k < 5; k++) begin
      int idx;
      bit ok;
      idx = (m_rr + k) % 5;
      ok  = m_occ[idx];
      for (int j = 0; j < 5; j++)
        if (m_occ[j] && j != idx && m_rd[j] == m_rd[idx] && m_seq[j] < m_seq[idx]) ok = 0;
      if (ok) begin
        if (e_a < 0) e_a = idx;
        else if (e_b < 0) e_b = idx;
      end
    end
    for (int i = 0; i < 5; i++) begin
      if (m_occ[i]) begin
        e_mask[m_rd[i]] = 1'b1;
        if (i != e_a && i != e_b) e_stall[i] = 1'b1;
      end
    end
  endtask

  task automatic model_commit(input logic [4:0] v, input logic [19:0] r, input logic [159:0] d);
    int last;
    if (PERF_ON && (|e_stall) && m_perf < PERF_MAX) m_perf++;
    if (e_a >= 0) m_occ[e_a] = 0;
    if (e_b >= 0) m_occ[e_b] = 0;
    last = (e_b >= 0) ? e_b : e_a;
    if (last >= 0) m_rr = (last + 1) % 5;
    for (int i = 0; i < 5; i++) begin
      if (v[i] && !e_stall[i]) begin
        m_occ[i] = 1;
        m_rd[i]  = r[4*i +: 4];
        m_val[i] = d[32*i +: 32];
        m_seq[i] = seq_ctr;
        seq_ctr++;
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    src_valid = '0;
    cycle();
    cycle();
    rst = 1'b0;
    model_reset();
  endtask

  task automatic set_src(input int u, input logic [3:0] r, input logic [31:0] v);
    src_valid[u]         = 1'b1;
    src_rd[4*u +: 4]     = r;
    src_value[32*u +: 32] = v;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cycle();
    checks++; if (wr_a_en !== 1'b0 || wr_b_en !== 1'b0) begin failures++; $display("FAIL rst_wr_en got=%b%b exp=00", wr_a_en, wr_b_en); end
    checks++; if (src_stall !== 5'b0) begin failures++; $display("FAIL rst_stall got=%b exp=0", src_stall); end
    rst = 1'b0;
    model_reset();
    for (int c = 0; c < 4; c++) begin
      cycle();
      checks++; if (wr_a_en !== 1'b0 || wr_b_en !== 1'b0) begin failures++; $display("FAIL idle_wr_en c=%0d got=%b%b exp=00", c, wr_a_en, wr_b_en); end
      checks++; if (pending_mask !== 16'h0000) begin failures++; $display("FAIL idle_mask c=%0d got=%h exp=0000", c, pending_mask); end
      checks++; if (src_stall !== 5'b0) begin failures++; $display("FAIL idle_stall c=%0d got=%b exp=0", c, src_stall); end
      checks++; if (perf_stall_cycles !== '0) begin failures++; $display("FAIL idle_perf c=%0d got=%0d exp=0", c, perf_stall_cycles); end
    end
  endtask

  task automatic test_two_ports();
    do_reset();
    set_src(0, 4'd3, 32'h11);
    set_src(4, 4'd7, 32'h22);
    cycle();
    src_valid = '0;
    checks++; if ({wr_a_en, wr_a_rd, wr_a_value} !== {1'b1, 4'd3, 32'h11}) begin failures++; $display("FAIL two_port_a got=%b/%0d/%h exp=1/3/11", wr_a_en, wr_a_rd, wr_a_value); end
    checks++; if ({wr_b_en, wr_b_rd, wr_b_value} !== {1'b1, 4'd7, 32'h22}) begin failures++; $display("FAIL two_port_b got=%b/%0d/%h exp=1/7/22", wr_b_en, wr_b_rd, wr_b_value); end
    checks++; if (pending_mask !== 16'h0088) begin failures++; $display("FAIL two_port_mask got=%h exp=0088", pending_mask); end
    cycle();
    checks++; if (pending_mask !== 16'h0000 || wr_a_en !== 1'b0) begin failures++; $display("FAIL two_port_after got=%h/%b exp=0000/0", pending_mask, wr_a_en); end
  endtask

  task automatic test_rotation();
    do_reset();
    set_src(0, 4'd1, 32'h101);
    set_src(1, 4'd2, 32'h102);
    set_src(3, 4'd4, 32'h104);
    cycle();
    src_valid = '0;
    checks++; if ({wr_a_en, wr_a_rd, wr_a_value} !== {1'b1, 4'd1, 32'h101}) begin failures++; $display("FAIL rot_c1_a got=%b/%0d/%h exp=1/1/101", wr_a_en, wr_a_rd, wr_a_value); end
    checks++; if ({wr_b_en, wr_b_rd, wr_b_value} !== {1'b1, 4'd2, 32'h102}) begin failures++; $display("FAIL rot_c1_b got=%b/%0d/%h exp=1/2/102", wr_b_en, wr_b_rd, wr_b_value); end
    checks++; if (src_stall !== 5'b01000) begin failures++; $display("FAIL rot_c1_stall got=%b exp=01000", src_stall); end
    cycle();
    checks++; if ({wr_a_en, wr_a_rd, wr_a_value, wr_b_en} !== {1'b1, 4'd4, 32'h104, 1'b0}) begin failures++; $display("FAIL rot_c2 got=%b/%0d/%h/%b exp=1/4/104/0", wr_a_en, wr_a_rd, wr_a_value, wr_b_en); end
    // rr_ptr should now be 4, so mul outranks alu_a.
    set_src(0, 4'd6, 32'h6);
    set_src(4, 4'd7, 32'h7);
    cycle();
    src_valid = '0;
    checks++; if ({wr_a_rd, wr_b_rd} !== {4'd7, 4'd6}) begin failures++; $display("FAIL rot_ptr4 got=%0d/%0d exp=7/6", wr_a_rd, wr_b_rd); end
  endtask

  task automatic test_waw();
    logic [31:0] seen[$];
    int both;
    do_reset();
    set_src(1, 4'd12, 32'h1);
    cycle();
    src_valid = '0;
    set_src(1, 4'd5, 32'hAA);
    set_src(2, 4'd9, 32'h9);
    set_src(3, 4'd10, 32'hA);
    cycle();
    src_valid = '0;
    checks++; if (src_stall !== 5'b00010) begin failures++; $display("FAIL waw_stall got=%b exp=00010", src_stall); end
    both = 0;
    for (int c = 0; c < 6; c++) begin
      if (wr_a_en && wr_a_rd == 4'd5) seen.push_back(wr_a_value);
      if (wr_b_en && wr_b_rd == 4'd5) seen.push_back(wr_b_value);
      if (wr_a_en && wr_b_en && wr_a_rd == wr_b_rd) both++;
      if (c == 0) set_src(4, 4'd5, 32'hBB);
      cycle();
      src_valid = '0;
    end
    checks++; if (both != 0) begin failures++; $display("FAIL waw_same_cycle got=%0d exp=0", both); end
    checks++; if (seen.size() != 2) begin failures++; $display("FAIL waw_count got=%0d exp=2", seen.size()); end
    checks++; if (seen.size() < 2 || seen[0] !== 32'hAA || seen[1] !== 32'hBB) begin failures++; $display("FAIL waw_order got=%p exp=AA,BB", seen); end
  endtask

  task automatic test_branch_stall();
    logic [PW-1:0] exp_p;
    do_reset();
    set_src(0, 4'd3, 32'hA1);
    set_src(1, 4'd3, 32'hB1);
    set_src(2, 4'd3, 32'hC3);
    cycle();
    src_valid[0] = 1'b0;
    src_valid[1] = 1'b0;
    checks++; if (wb_stall_branch !== 1'b1 || {wr_a_en, wr_a_value, wr_b_en} !== {1'b1, 32'hA1, 1'b0}) begin failures++; $display("FAIL br_c1 got=%b/%b/%h/%b exp=1/1/a1/0", wb_stall_branch, wr_a_en, wr_a_value, wr_b_en); end
    cycle();
    checks++; if (wb_stall_branch !== 1'b1 || {wr_a_en, wr_a_value, wr_b_en} !== {1'b1, 32'hB1, 1'b0}) begin failures++; $display("FAIL br_c2 got=%b/%b/%h/%b exp=1/1/b1/0", wb_stall_branch, wr_a_en, wr_a_value, wr_b_en); end
    cycle();
    src_valid = '0;
    checks++; if (wb_stall_branch !== 1'b0 || {wr_a_en, wr_a_rd, wr_a_value} !== {1'b1, 4'd3, 32'hC3}) begin failures++; $display("FAIL br_c3 got=%b/%b/%0d/%h exp=0/1/3/c3", wb_stall_branch, wr_a_en, wr_a_rd, wr_a_value); end
    exp_p = PERF_ON ? PW'(2) : PW'(0);
    checks++; if (perf_stall_cycles !== exp_p) begin failures++; $display("FAIL br_perf got=%0d exp=%0d", perf_stall_cycles, exp_p); end
    cycle();
    checks++; if (wr_a_en !== 1'b0 || pending_mask !== 16'h0) begin failures++; $display("FAIL br_c4 got=%b/%h exp=0/0000", wr_a_en, pending_mask); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int u = 0; u < 5; u++) set_src(u, 4'(8 + u), 32'h50 + 32'(u));
    cycle();
    checks++; if (pending_mask !== 16'h1F00 || src_stall !== 5'b11100) begin failures++; $display("FAIL five_cap got=%h/%b exp=1f00/11100", pending_mask, src_stall); end
    rst = 1'b1;
    #1;
    checks++; if (wr_a_en !== 1'b0 || wr_b_en !== 1'b0) begin failures++; $display("FAIL rst_cycle_wr got=%b%b exp=00", wr_a_en, wr_b_en); end
    cycle();
    rst = 1'b0;
    src_valid = '0;
    model_reset();
    #1;
    checks++; if (pending_mask !== 16'h0 || src_stall !== 5'b0 || wr_a_en !== 1'b0) begin failures++; $display("FAIL rst_mid got=%h/%b/%b exp=0000/0/0", pending_mask, src_stall, wr_a_en); end
    checks++; if (perf_stall_cycles !== '0) begin failures++; $display("FAIL rst_mid_perf got=%0d exp=0", perf_stall_cycles); end
    cycle();
    checks++; if (wr_a_en !== 1'b0 || pending_mask !== 16'h0) begin failures++; $display("FAIL rst_mid_after got=%b/%h exp=0/0000", wr_a_en, pending_mask); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      model_eval();
      checks++; if (wr_a_en !== (e_a >= 0)) begin failures++; $display("FAIL rnd_a_en c=%0d got=%b exp=%b", c, wr_a_en, (e_a >= 0)); end
      if (e_a >= 0) begin
        checks++; if ({wr_a_rd, wr_a_value} !== {m_rd[e_a], m_val[e_a]}) begin failures++; $display("FAIL rnd_a_data c=%0d got=%0d/%h exp=%0d/%h", c, wr_a_rd, wr_a_value, m_rd[e_a], m_val[e_a]); end
      end
      checks++; if (wr_b_en !== (e_b >= 0)) begin failures++; $display("FAIL rnd_b_en c=%0d got=%b exp=%b", c, wr_b_en, (e_b >= 0)); end
      if (e_b >= 0) begin
        checks++; if ({wr_b_rd, wr_b_value} !== {m_rd[e_b], m_val[e_b]}) begin failures++; $display("FAIL rnd_b_data c=%0d got=%0d/%h exp=%0d/%h", c, wr_b_rd, wr_b_value, m_rd[e_b], m_val[e_b]); end
      end
      checks++; if (src_stall !== e_stall || wb_stall_branch !== e_stall[2]) begin failures++; $display("FAIL rnd_stall c=%0d got=%b/%b exp=%b", c, src_stall, wb_stall_branch, e_stall); end
      checks++; if (pending_mask !== e_mask) begin failures++; $display("FAIL rnd_mask c=%0d got=%h exp=%h", c, pending_mask, e_mask); end
      checks++; if (perf_stall_cycles !== PW'(m_perf)) begin failures++; $display("FAIL rnd_perf c=%0d got=%0d exp=%0d", c, perf_stall_cycles, m_perf); end
      for (int u = 0; u < 5; u++) begin
        src_valid[u]          = ($urandom_range(0, 9) < 6);
        src_rd[4*u +: 4]      = 4'($urandom_range(0, 3));
        src_value[32*u +: 32] = $urandom;
      end
      model_commit(src_valid, src_rd, src_value);
      cycle();
    end
    src_valid = '0;
  endtask

  initial begin
    clk       = 1'b0;
    rst       = 1'b1;
    src_valid = '0;
    src_rd    = '0;
    src_value = '0;
    model_reset();
    test_reset();
    test_two_ports();
    test_rotation();
    test_waw();
    test_branch_stall();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/core_writeback_arbiter.md
Name: core_writeback_arbiter

Overview:
- Schedules results from the five execution units (alu_a, alu_b, branch, ldst, mul) onto the two register-file write ports.
- Each unit owns a one-entry result buffer. Up to two buffered results retire per cycle under rotating priority, with per-register write ordering preserved.
- Produces the per-unit stall back-pressure, including wb_stall_branch, and the pending-write register mask consumed by dispatch hazard checking.

Parameters:
- RR_INIT, 0, initial round-robin pointer (0..4) after reset.
- PERF_W, 32, width of the optional stall-cycle counter.

Ports:
- clk  in  1  core clock
- rst  in  1  reset, synchronous, active-high
- src_valid  in  5  per-unit result valid; index 0=alu_a, 1=alu_b, 2=branch, 3=ldst, 4=mul
- src_rd  in  20  per-unit destination register, 4 bits each, unit i at [4i+3:4i]
- src_value  in  160  per-unit result word, 32 bits each, unit i at [32i+31:32i]
- src_stall  out  5  per-unit back-pressure; unit must hold its result while set
- wb_stall_branch  out  1  equals src_stall[2]
- wr_a_en  out  1  write port A enable
- wr_a_rd  out  4  write port A register
- wr_a_value  out  32  write port A data
- wr_b_en  out  1  write port B enable
- wr_b_rd  out  4  write port B register
- wr_b_value  out  32  write port B data
- pending_mask  out  16  one-hot OR of the rd of every occupied buffer (hword)
- perf_stall_cycles  out  PERF_W  only with WB_PERF_EN, else tied 0

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- State per unit i:
  - occ[i], rd[i], val[i]
  - older[i][j] matrix: 1 = entry i arrived before entry j
  - rr_ptr, 3 bits, range 0..4
- Reset values:
  - all occ = 0 and all older = 0; rr_ptr = RR_INIT
  - all outputs 0: wr_*_en, pending_mask, src_stall, perf_stall_cycles
- Eligibility: entry i is eligible iff occ[i] and no occupied j with rd[j]==rd[i] and older[j][i]=1.
- Grant:
  - Scan eligible entries starting at rr_ptr, wrapping 4 -> 0.
  - First hit drives port A, second hit drives port B.
  - Two granted entries never share an rd; guaranteed by eligibility.
  - Write ports are combinational from buffer state; wr_x_en = grant exists.
- Clear: granted entries clear occ at the clock edge.
- rr_ptr update:
  - advances to (last granted index + 1) mod 5
  - unchanged when nothing is granted
- Stall: src_stall[i] = occ[i] and not granted this cycle. Combinational, from registered state only; never depends on src_valid.
- Capture: src_valid[i] and !src_stall[i] loads the buffer at the edge; occ set, rd/value latched.
  - Minimum latency from valid to write is 1 cycle.
  - A granted entry may be refilled in the same cycle.
- Age on capture:
  - older[j][i] = 1 for every j occupied and not cleared this cycle; older[i][j] = 0.
  - Same-cycle captures with equal rd: lower index is older. Dispatch order is alu_a before alu_b.
  - On clear of i: row i and column i are zeroed.
- pending_mask is built from registered occ/rd. Entries granted this cycle stay visible until the edge.
- Simultaneous events:
  - five captures in one cycle: all accepted when buffers empty
  - more than two eligible: at most two retire, the rest stall the following cycle
- Reset mid-operation discards all buffered results; no write is issued in the reset cycle.

Optional Feature:
- Macro WB_PERF_EN.
- Defined:
  - perf_stall_cycles increments each cycle in which |src_stall is 1.
  - saturates at all-ones; cleared by rst.
- Undefined: no counter logic; perf_stall_cycles driven constant 0.

Test Plan:
- Reset, then idle 4 cycles -> wr_a_en=wr_b_en=0, pending_mask=16'h0000, src_stall=0.
- Cycle 0: alu_a r3=32'h11 and mul r7=32'h22 valid -> cycle 1: port A r3/0x11, port B r7/0x22; pending_mask=16'h0088 in cycle 1 only.
- Cycle 0: alu_a, alu_b, ldst valid (r1,r2,r4), rr_ptr=0 -> cycle 1: A=r1, B=r2, src_stall[3]=1; cycle 2: A=r4, rr_ptr=4.
- WAW ordering:
  - Cycle 0: alu_b r5=0xAA.
  - Cycle 1: port A is occupied by an older r2 from alu_a; mul r5=0xBB captured.
  - Required: r5 written 0xAA strictly before 0xBB, never on both ports in one cycle.
- Hold branch buffer occupied while two older entries win -> wb_stall_branch=1 for those cycles; the branch result retires next and is not lost when src_valid[2] stays held.
- WB_PERF_EN: 3 stall cycles -> perf_stall_cycles=3; preload near all-ones -> stays saturated; rst mid-burst -> counter 0 and all occ 0 next cycle.
